// File: rtl/in_key_pio.sv
// in_key_pio: Avalon-MM slave input PIO for keypad and coin sensors (sync, debounce, edge capture, irq).
// Latency: in_port change -> DATA readdata in 3 cycles, plus DEBOUNCE_CYCLES when debounce is built; read latency 1.
// Backpressure: none; every access completes in one cycle, there is no waitrequest.
//
// Build option: define IN_KEY_PIO_DEBOUNCE_EN to add one debounce counter per input bit.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   address, chipselect,  register select and active-low write strobe (qualified by chipselect)
//   write_n, writedata
//   in_port               asynchronous external inputs
//   readdata              registered read data (addr 0 DATA, 1 reserved, 2 IRQ_MASK, 3 EDGE_CAPTURE W1C)
//   irq                   level interrupt, |(edge_capture & irq_mask)
module in_key_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] readdata,
  output logic             irq
);

  if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 1 || EDGE_TYPE < 0 || EDGE_TYPE > 2) begin : g_bad_param
    $error("in_key_pio: parameter out of range");
  end

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] filt_d;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_sel;
  logic [WIDTH-1:0] edge_en;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] clr_mask;
  logic [1:0]       arm_cnt;
  logic             armed;
  logic             wr_en;

  assign wr_en = chipselect && !write_n;
  // Edge detection stays off for the first three cycles after reset so the
  // sync/filter pipeline can fill from its all-zero reset state.
  assign armed = (arm_cnt == 2'd3);

  // Two-flop synchroniser: nothing downstream ever sees raw in_port.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef IN_KEY_PIO_DEBOUNCE_EN
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0]    db_cnt [WIDTH];
  // A bit becomes ready once, after arming, its synchronised input agrees with
  // the accepted value. An input still being debounced at arming time (held
  // through reset) therefore has its first acceptance absorbed, not reported.
  logic [WIDTH-1:0] ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      filt  <= '0;
      ready <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          filt[i]   <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
      ready <= ready | ({WIDTH{armed}} & ~(sync2 ^ filt));
    end
  end

  assign edge_en = ready;
`else
  assign filt    = sync2;
  assign edge_en = {WIDTH{armed}};
`endif

  always_comb begin
    edge_sel = filt ^ filt_d;
    if (EDGE_TYPE == 0) begin
      edge_sel = filt & ~filt_d;
    end else if (EDGE_TYPE == 1) begin
      edge_sel = ~filt & filt_d;
    end
  end

  assign edge_set = edge_sel & edge_en;
  assign clr_mask = (wr_en && address == 2'd3) ? writedata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_d       <= '0;
      arm_cnt      <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      readdata     <= '0;
    end else begin
      filt_d <= filt;
      if (!armed) begin
        arm_cnt <= arm_cnt + 2'd1;
      end
      if (wr_en && address == 2'd2) begin
        irq_mask <= writedata;
      end
      // Set after clear: an edge arriving with a W1C of the same bit wins.
      edge_capture <= (edge_capture & ~clr_mask) | edge_set;
      case (address)
        2'd0:    readdata <= filt;
        2'd2:    readdata <= irq_mask;
        2'd3:    readdata <= edge_capture;
        default: readdata <= '0;
      endcase
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule
